// File: rtl/pw_conv_pkg.sv
// Shared types and defaults for the pointwise convolution sequencer.
// Holds the controller state encoding and the filter-group enable mask helper.
package pw_conv_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    localparam int DEF_NUM_PE    = 4;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_CH_W      = 10;
    localparam int DEF_FILT_W    = 10;
    localparam int DEF_PIX_W     = 16;
    localparam int DEF_DRAIN_CYC = 3;
    localparam int MAX_PE        = 16;

    // fbase is the index of the group's first filter (g*num_pe), kept as a running sum by the caller
    function automatic logic [MAX_PE-1:0] grp_mask(input int unsigned f, input int unsigned fbase,
                                                   input int unsigned num_pe);
        logic [MAX_PE-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAX_PE; k++)
            m[k] = (k < num_pe) && (fbase + k < f);
        return m;
    endfunction

endpackage

// File: rtl/pw_loop_cnt.sv
// Three-level nested loop counter: channel c innermost, then group g, then pixel p.
// Reports the last-channel, last-group and final-iteration conditions of the current count.
module pw_loop_cnt #(
    parameter int CH_W  = 10,
    parameter int G_W   = 10,
    parameter int PIX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [CH_W-1:0]  c_max,
    input  logic [G_W-1:0]   g_max,
    input  logic [PIX_W-1:0] p_max,
    output logic [CH_W-1:0]  c,
    output logic             c_last,
    output logic             g_last,
    output logic             last
);

    logic [G_W-1:0]   g;
    logic [PIX_W-1:0] p;

    assign c_last = (c == c_max);
    assign g_last = (g == g_max);
    assign last   = c_last && g_last && (p == p_max);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            c <= '0;
            g <= '0;
            p <= '0;
        end else if (en) begin
            if (c_last) begin
                c <= '0;
                if (g_last) begin
                    g <= '0;
                    p <= last ? '0 : p + 1'b1;
                end else begin
                    g <= g + 1'b1;
                end
            end else begin
                c <= c + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pw_conv_ctrl_param.sv
// Pointwise (1x1) convolution sequencer: walks pixels x filter groups x channels and drives
// IFM/weight buffer addresses plus per-PE enable/finish strobes, then drains and pulses done.
module pw_conv_ctrl_param
    import pw_conv_pkg::*;
#(
    parameter int NUM_PE    = DEF_NUM_PE,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CH_W      = DEF_CH_W,
    parameter int FILT_W    = DEF_FILT_W,
    parameter int PIX_W     = DEF_PIX_W,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cal_start,
    input  logic              valid,
    input  logic [CH_W-1:0]   weight_c,
    input  logic [FILT_W-1:0] num_filter,
    input  logic [PIX_W-1:0]  num_pixel,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] wgt_base,
    output logic [ADDR_W-1:0] addr_ifm,
    output logic [ADDR_W-1:0] addr_weight,
    output logic [NUM_PE-1:0] PE_en,
    output logic [NUM_PE-1:0] PE_finish,
    output logic              busy,
    output logic              done
);

    localparam int LOG2_PE = $clog2(NUM_PE);
    localparam int DW      = $clog2(DRAIN_CYC + 1) + 1;

    state_t            state;
    logic [CH_W-1:0]   c_r, c_max_r, c_idx;
    logic [FILT_W-1:0] f_r, g_max_r;
    logic [PIX_W-1:0]  p_max_r;
    logic [FILT_W:0]   g_tot, fbase;
    logic [ADDR_W-1:0] wgt_base_r, pix_base, grp_base;
    logic [DW-1:0]     dcnt;
    logic [NUM_PE-1:0] mask;
    logic              c_last, g_last, last_iss, issue;

    // ceil(F / NUM_PE) with NUM_PE a power of two
    assign g_tot = ({1'b0, num_filter} + (FILT_W+1)'(NUM_PE - 1)) >> LOG2_PE;
    assign mask  = NUM_PE'(grp_mask(32'(f_r), 32'(fbase), NUM_PE));
    assign issue = (state == RUN) && valid;

    pw_loop_cnt #(.CH_W(CH_W), .G_W(FILT_W), .PIX_W(PIX_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == LOAD),
        .en     (issue),
        .c_max  (c_max_r),
        .g_max  (g_max_r),
        .p_max  (p_max_r),
        .c      (c_idx),
        .c_last (c_last),
        .g_last (g_last),
        .last   (last_iss)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_ifm    <= '0;
            addr_weight <= '0;
            PE_en       <= '0;
            PE_finish   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            c_r         <= '0;
            c_max_r     <= '0;
            f_r         <= '0;
            g_max_r     <= '0;
            p_max_r     <= '0;
            fbase       <= '0;
            wgt_base_r  <= '0;
            pix_base    <= '0;
            grp_base    <= '0;
            dcnt        <= '0;
        end else begin
            PE_en     <= '0;
            PE_finish <= '0;
            done      <= 1'b0;
            case (state)
                IDLE: if (cal_start) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    c_r        <= weight_c;
                    c_max_r    <= weight_c - 1'b1;
                    f_r        <= num_filter;
                    g_max_r    <= FILT_W'(g_tot - 1'b1);
                    p_max_r    <= num_pixel - 1'b1;
                    fbase      <= '0;
                    pix_base   <= ifm_base;
                    grp_base   <= wgt_base;
                    wgt_base_r <= wgt_base;
                    if (weight_c == '0 || num_filter == '0 || num_pixel == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: if (valid) begin
                    addr_ifm    <= pix_base + ADDR_W'(c_idx);
                    addr_weight <= grp_base + ADDR_W'(c_idx);
                    PE_en       <= mask;
                    PE_finish   <= c_last ? mask : '0;
                    // running bases replace p*C and g*C products
                    if (c_last) begin
                        if (g_last) begin
                            grp_base <= wgt_base_r;
                            fbase    <= '0;
                            pix_base <= pix_base + ADDR_W'(c_r);
                        end else begin
                            grp_base <= grp_base + ADDR_W'(c_r);
                            fbase    <= fbase + (FILT_W+1)'(NUM_PE);
                        end
                    end
                    if (last_iss) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(DRAIN_CYC - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
